// File: rtl/rom_load_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rom_load_pkg
// Brief   : Shared types, file indices and ROM region decoder for rom_load_ctrl
// Revision: 1.0
// ============================================================================
package rom_load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_TNO = 8'd1;

  typedef struct packed {
    logic        in_range;
    logic [31:0] sel;
  } region_t;

  // Upper address bits pick the region; anything above the top region is out of range.
  function automatic region_t region_decode(input logic [24:0] addr,
                                            input int          addr_w,
                                            input int          reg_w);
    region_t     r;
    logic [24:0] idx;
    idx        = (addr >> addr_w) & ((25'd1 << reg_w) - 25'd1);
    r.in_range = ((addr >> (addr_w + reg_w)) == 25'd0);
    r.sel      = 32'd1 << idx;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : rom_load_ctrl_if
// Brief   : ioctl download bus in, core ROM write bus out
// Revision: 1.0
// ============================================================================
interface rom_load_ctrl_if #(
  parameter int NREG   = 4,
  parameter int ADDR_W = 17
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              rom_wr;
  logic [NREG-1:0]   rom_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_dout;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  rom_wr, rom_sel, rom_addr, rom_dout
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output rom_wr, rom_sel, rom_addr, rom_dout
  );
endinterface
`default_nettype wire

// File: rtl/rom_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rom_load_ctrl
// Brief   : Routes HPS ioctl ROM download into core ROM regions, captures the
//           title number and sequences the game-core reset around the load.
// Revision: 1.0
// ============================================================================
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int          NREG         = 4,
  parameter int          ADDR_W       = 17,
  parameter int          RELEASE_CYC  = 16,
  parameter logic [24:0] EXPECT_BYTES = 25'h40000
) (
  input  wire logic          clk_sys,
  input  wire logic          reset,
  rom_load_ctrl_if.slave     bus,
  input  wire logic          user_rst,
  output logic [3:0]         tno,
  output logic               core_reset,
  output logic               load_done,
  output logic               load_err,
  output logic [24:0]        byte_count
);

  localparam int REG_W = $clog2(NREG);
  localparam int CNT_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(RELEASE_CYC - 1);

  state_t           r_state;
  logic             r_dl_prev;
  logic             r_stray;
  logic             r_hold_dl;
  logic [CNT_W-1:0] r_cnt;

  region_t w_dec;
  logic    w_rise;
  logic    w_fall;
  logic    w_in_range;
  logic    w_window;
  logic    w_wr_rom;
  logic    w_wr_stray;
  logic    w_wr_tno;
  logic    w_load_ok;

  always_comb begin
    w_dec      = region_decode(bus.ioctl_addr, ADDR_W, REG_W);
    // Select bits above NREG can only be set when the address is out of range.
    w_in_range = w_dec.in_range & ((w_dec.sel >> NREG) == 32'd0);
    w_rise     = bus.ioctl_download & ~r_dl_prev;
    w_fall     = ~bus.ioctl_download & r_dl_prev;
    // A rising edge enters LOAD in the same cycle, so its write is accepted too.
    w_window   = (r_state == LOAD) | w_rise;
    w_wr_rom   = w_window & bus.ioctl_wr & (bus.ioctl_index == IDX_ROM) & w_in_range;
    w_wr_stray = w_window & bus.ioctl_wr & (bus.ioctl_index == IDX_ROM) & ~w_in_range;
    w_wr_tno   = w_window & bus.ioctl_wr & (bus.ioctl_index == IDX_TNO);
    w_load_ok  = (byte_count == EXPECT_BYTES) & ~r_stray;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= IDLE;
      r_dl_prev    <= 1'b0;
      r_stray      <= 1'b0;
      r_hold_dl    <= 1'b0;
      r_cnt        <= '0;
      bus.rom_wr   <= 1'b0;
      bus.rom_sel  <= '0;
      bus.rom_addr <= '0;
      bus.rom_dout <= 8'd0;
      tno          <= 4'd0;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      byte_count   <= 25'd0;
    end else begin
      r_dl_prev  <= bus.ioctl_download;
      bus.rom_wr <= w_wr_rom;
      if (w_wr_rom) begin
        bus.rom_sel  <= w_dec.sel[NREG-1:0];
        bus.rom_addr <= bus.ioctl_addr[ADDR_W-1:0];
        bus.rom_dout <= bus.ioctl_dout;
      end else begin
        bus.rom_sel  <= '0;
      end
      if (w_wr_tno) begin
        tno <= bus.ioctl_dout[3:0];
      end

      if (w_rise) begin
        r_state    <= LOAD;
        core_reset <= 1'b1;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
        r_stray    <= w_wr_stray;
        byte_count <= w_wr_rom ? 25'd1 : 25'd0;
      end else begin
        case (r_state)
          IDLE: begin
            core_reset <= 1'b1;
          end
          LOAD: begin
            core_reset <= 1'b1;
            if (w_wr_rom && (byte_count != '1)) begin
              byte_count <= byte_count + 25'd1;
            end
            if (w_wr_stray) begin
              r_stray <= 1'b1;
            end
            if (w_fall) begin
              r_state   <= HOLD;
              r_cnt     <= c_RELOAD;
              r_hold_dl <= 1'b1;
            end
          end
          HOLD: begin
            core_reset <= 1'b1;
            if (user_rst) begin
              r_cnt <= c_RELOAD;
            end else if (r_cnt == '0) begin
              if (r_hold_dl) begin
                load_done <= w_load_ok;
                load_err  <= ~w_load_ok;
              end
              // A bad load parks in IDLE with the core held in reset.
              if (r_hold_dl ? w_load_ok : ~load_err) begin
                r_state    <= RUN;
                core_reset <= 1'b0;
              end else begin
                r_state    <= IDLE;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          RUN: begin
            if (user_rst) begin
              r_state    <= HOLD;
              r_cnt      <= c_RELOAD;
              r_hold_dl  <= 1'b0;
              core_reset <= 1'b1;
            end
          end
          default: begin
            r_state    <= IDLE;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rom_load_ctrl
// Brief   : Scoreboard bench for rom_load_ctrl on a reduced region size
// Revision: 1.0
// ============================================================================
module tb_rom_load_ctrl;
  import rom_load_pkg::*;

  localparam int          NREG         = 4;
  localparam int          ADDR_W       = 8;
  localparam int          RELEASE_CYC  = 16;
  localparam logic [24:0] EXPECT_BYTES = 25'h400;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        user_rst = 1'b0;
  logic [3:0]  tno;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [24:0] byte_count;

  rom_load_ctrl_if #(.NREG(NREG), .ADDR_W(ADDR_W)) bus();

  rom_load_ctrl #(
    .NREG(NREG), .ADDR_W(ADDR_W), .RELEASE_CYC(RELEASE_CYC), .EXPECT_BYTES(EXPECT_BYTES)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus), .user_rst(user_rst), .tno(tno),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [19:0] sb_q[$];
  logic [19:0] mon_e;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [19:0] exp_item(input logic [24:0] a, input logic [7:0] d);
    logic [3:0] s;
    s = 4'b0001 << a[9:8];
    return {s, a[7:0], d};
  endfunction

  task automatic send_wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    if (idx == 8'd0 && a < 25'(NREG << ADDR_W)) sb_q.push_back(exp_item(a, d));
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  // Ends one cycle after the falling download edge has been sampled.
  task automatic do_load(input int n, input logic [7:0] tval, input bit stray, input bit last_on_fall);
    bus.ioctl_download = 1'b1;
    send_wr(8'd1, 25'd0, tval);
    check_eq("tno", 64'(tno), 64'(tval[3:0]));
    for (int i = 0; i < n; i++) begin
      if (last_on_fall && i == n - 1) bus.ioctl_download = 1'b0;
      send_wr(8'd0, 25'(i), 8'(i * 13 + 7));
      if (i == 'h205) begin
        check_eq("probe_rom_wr", 64'(bus.rom_wr), 64'd1);
        check_eq("probe_rom_sel", 64'(bus.rom_sel), 64'(4'b0100));
        check_eq("probe_rom_addr", 64'(bus.rom_addr), 64'h05);
      end
    end
    if (stray) send_wr(8'd0, 25'h8_0000, 8'hAA);
    if (!last_on_fall) begin
      tick();
      bus.ioctl_download = 1'b0;
      tick();
    end
  endtask

  task automatic wait_release(input string tag);
    int cyc = 0;
    while (core_reset === 1'b1 && cyc < 64) begin
      tick();
      cyc++;
    end
    check_eq(tag, 64'(cyc), 64'(RELEASE_CYC));
  endtask

  always @(negedge clk_sys) begin
    if (bus.rom_wr === 1'b1) begin
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("rom_wr_data", 64'({bus.rom_sel, bus.rom_addr, bus.rom_dout}), 64'(mon_e));
      end else begin
        check_eq("rom_wr_spurious", 64'(bus.rom_wr), 64'd0);
      end
    end
  end

  initial begin
    int hi;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;
    bus.ioctl_index    = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();

    // Idle after reset
    check_eq("rst_core_reset", 64'(core_reset), 64'd1);
    check_eq("rst_tno", 64'(tno), 64'd0);
    check_eq("rst_load_done", 64'(load_done), 64'd0);
    check_eq("rst_load_err", 64'(load_err), 64'd0);
    check_eq("rst_byte_count", 64'(byte_count), 64'd0);
    check_eq("rst_rom_wr", 64'(bus.rom_wr), 64'd0);

    // Full good load
    do_load(1024, 8'h02, 1'b0, 1'b0);
    check_eq("good_byte_count", 64'(byte_count), 64'h400);
    wait_release("good_release_delay");
    check_eq("good_load_done", 64'(load_done), 64'd1);
    check_eq("good_load_err", 64'(load_err), 64'd0);
    check_eq("good_tno", 64'(tno), 64'd2);

    // Short load
    do_load(1023, 8'h05, 1'b0, 1'b0);
    repeat (24) tick();
    check_eq("short_byte_count", 64'(byte_count), 64'h3FF);
    check_eq("short_load_err", 64'(load_err), 64'd1);
    check_eq("short_load_done", 64'(load_done), 64'd0);
    check_eq("short_core_reset", 64'(core_reset), 64'd1);
    check_eq("short_state", 64'(dut.r_state), 64'(IDLE));
    send_wr(8'd1, 25'd0, 8'h0C);
    tick();
    check_eq("tno_outside_load", 64'(tno), 64'd5);

    // Full-size load plus one out-of-range byte
    do_load(1024, 8'h03, 1'b1, 1'b0);
    check_eq("stray_byte_count", 64'(byte_count), 64'h400);
    repeat (24) tick();
    check_eq("stray_load_err", 64'(load_err), 64'd1);
    check_eq("stray_load_done", 64'(load_done), 64'd0);
    check_eq("stray_core_reset", 64'(core_reset), 64'd1);

    // Good load whose last byte coincides with the falling edge, then user reset
    do_load(1024, 8'h07, 1'b0, 1'b1);
    wait_release("fall_release_delay");
    check_eq("fall_byte_count", 64'(byte_count), 64'h400);
    check_eq("fall_load_done", 64'(load_done), 64'd1);
    hi = 0;
    user_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (core_reset === 1'b1) hi++;
    end
    user_rst = 1'b0;
    while (core_reset === 1'b1 && hi < 64) begin
      tick();
      if (core_reset === 1'b1) hi++;
    end
    check_eq("user_rst_hold", 64'(hi), 64'(3 + RELEASE_CYC - 1));
    check_eq("user_rst_load_done", 64'(load_done), 64'd1);
    check_eq("user_rst_load_err", 64'(load_err), 64'd0);

    // Reset in the middle of a load, then a clean reload
    bus.ioctl_download = 1'b1;
    send_wr(8'd1, 25'd0, 8'h04);
    for (int i = 0; i < 100; i++) send_wr(8'd0, 25'(i), 8'(i ^ 8'h5A));
    repeat (2) tick();
    check_eq("mid_byte_count", 64'(byte_count), 64'd100);
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    tick();
    check_eq("midrst_state", 64'(dut.r_state), 64'(IDLE));
    check_eq("midrst_byte_count", 64'(byte_count), 64'd0);
    check_eq("midrst_rom_wr", 64'(bus.rom_wr), 64'd0);
    check_eq("midrst_core_reset", 64'(core_reset), 64'd1);
    reset = 1'b0;
    tick();
    do_load(1024, 8'h09, 1'b0, 1'b0);
    wait_release("reload_release_delay");
    check_eq("reload_load_done", 64'(load_done), 64'd1);
    check_eq("reload_tno", 64'(tno), 64'd9);

    repeat (4) tick();
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
